call_control: RTL and testbench

// - Call-state controller at the far end of the user_interface command link: accepts UI commands
//   (dial/accept/reject/hangup) and drives UI status back via inc_command, init, incoming_call.
// - Exchanges call-signalling packets with the network layer through a valid/ready TX port and a valid-only RX port.
// - Sits between user_interface and the packet transport in the telephony top level.

---
 rtl/call_control.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_call_control.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/call_control.sv
// ---------------------------------------------------------------------------
// call_control
//
// Call-state controller at the far end of the user_interface command link.
// It turns UI commands (dial / accept / reject / hangup) and received
// call-signalling packets into call-state transitions. It sends outgoing
// signalling packets to the network layer and reports call status back to
// the UI.
//
// States: IDLE, DIALING, RINGING, CONNECTED. A shared timer bounds the time
// spent in DIALING and RINGING.
//
// Optional feature macro:
//   CALL_CTRL_AUTOANSWER_EN - when defined, a call left ringing for
//   AUTO_ANS_CYCLES cycles is answered as if the user had pressed ACCEPT.
//   This only has an effect when AUTO_ANS_CYCLES < TIMEOUT_CYCLES.
//   When undefined, no auto-answer logic is built.
//
// Parameters:
//   TIMEOUT_CYCLES   cycles spent in DIALING/RINGING before giving up
//   AUTO_ANS_CYCLES  ringing cycles before auto-answer (macro builds only)
//   ADDR_W           station address width
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous active-high reset
//   ui_cmd         in   3b UI command: 0 NOP, 1 DIAL, 2 ACCEPT, 3 REJECT,
//                       4 HANGUP, 5-7 ignored
//   ui_cmd_valid   in   one-cycle strobe qualifying ui_cmd / ui_addr
//   ui_addr        in   destination address for DIAL
//   rx_valid       in   one-cycle strobe: received packet
//   rx_type        in   3b packet type: 1 CALL_REQ, 2 CALL_ACK, 3 CALL_NAK,
//                       4 CALL_END, others ignored
//   rx_src         in   sender address of the received packet
//   tx_valid       out  packet request, held until tx_ready
//   tx_type        out  packet type (same codes as rx_type)
//   tx_dst         out  packet destination
//   tx_ready       in   transport takes the packet when tx_valid && tx_ready
//   inc_command    out  UI status pulse: 1 RING, 2 CONNECTED, 3 BUSY,
//                       4 ENDED, 5 TIMEOUT, else 0
//   init           out  one-cycle pulse in the first cycle after reset
//   incoming_call  out  level, high while RINGING
//   peer_addr      out  address of the current or last peer
//
// Every output is registered. The response to a strobe appears one cycle
// later.
// ---------------------------------------------------------------------------
module call_control #(
  parameter int unsigned TIMEOUT_CYCLES  = 27_000_000,
  parameter int unsigned AUTO_ANS_CYCLES = 81_000_000,
  parameter int unsigned ADDR_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        ui_cmd,
  input  logic              ui_cmd_valid,
  input  logic [ADDR_W-1:0] ui_addr,
  input  logic              rx_valid,
  input  logic [2:0]        rx_type,
  input  logic [ADDR_W-1:0] rx_src,
  output logic              tx_valid,
  output logic [2:0]        tx_type,
  output logic [ADDR_W-1:0] tx_dst,
  input  logic              tx_ready,
  output logic [2:0]        inc_command,
  output logic              init,
  output logic              incoming_call,
  output logic [ADDR_W-1:0] peer_addr
);

  // UI command codes
  localparam logic [2:0] CMD_DIAL   = 3'd1;
  localparam logic [2:0] CMD_ACCEPT = 3'd2;
  localparam logic [2:0] CMD_REJECT = 3'd3;
  localparam logic [2:0] CMD_HANGUP = 3'd4;

  // Packet type codes (shared by rx and tx)
  localparam logic [2:0] PKT_NONE = 3'd0;
  localparam logic [2:0] PKT_REQ  = 3'd1;
  localparam logic [2:0] PKT_ACK  = 3'd2;
  localparam logic [2:0] PKT_NAK  = 3'd3;
  localparam logic [2:0] PKT_END  = 3'd4;

  // UI status codes
  localparam logic [2:0] UI_NONE      = 3'd0;
  localparam logic [2:0] UI_RING      = 3'd1;
  localparam logic [2:0] UI_CONNECTED = 3'd2;
  localparam logic [2:0] UI_BUSY      = 3'd3;
  localparam logic [2:0] UI_ENDED     = 3'd4;
  localparam logic [2:0] UI_TIMEOUT   = 3'd5;

  // The timer must be able to hold the largest compare value in any build.
  localparam int unsigned TMR_LIMIT = (AUTO_ANS_CYCLES > TIMEOUT_CYCLES) ?
                                      AUTO_ANS_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned TMR_W     = (TMR_LIMIT > 2) ? $clog2(TMR_LIMIT) : 1;
  localparam logic [TMR_W-1:0] TMR_SAT  = {TMR_W{1'b1}};
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
`ifdef CALL_CTRL_AUTOANSWER_EN
  localparam logic [TMR_W-1:0] AA_LAST  = TMR_W'(AUTO_ANS_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DIALING   = 2'd1,
    S_RINGING   = 2'd2,
    S_CONNECTED = 2'd3
  } state_e;

  // Registered state and outputs
  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [ADDR_W-1:0]  peer_addr_q, peer_addr_d;
  logic               tx_valid_q, tx_valid_d;
  logic [2:0]         tx_type_q, tx_type_d;
  logic [ADDR_W-1:0]  tx_dst_q, tx_dst_d;
  logic [2:0]         inc_command_q, inc_command_d;
  logic               incoming_call_q, incoming_call_d;
  logic               init_q, init_d;
  logic               started_q, started_d;

  // Event decode shared by the next-state and output processes
  logic               ui_ev_s;       // UI command that survived rx arbitration
  logic               rx_peer_s;     // packet from the current peer
  logic               timeout_s;
  logic               auto_ans_s;
  logic               send_s;        // FSM-generated packet request
  logic [2:0]         send_type_s;
  logic [ADDR_W-1:0]  send_dst_s;
  logic               nak_s;         // auto-reject of a stranger's CALL_REQ
  logic [2:0]         status_s;

  // A received packet always wins, so a coincident UI command is discarded.
  assign ui_ev_s   = ui_cmd_valid && !rx_valid;
  assign rx_peer_s = rx_valid && (rx_src == peer_addr_q);
  assign timeout_s = (timer_q == TMO_LAST);
`ifdef CALL_CTRL_AUTOANSWER_EN
  assign auto_ans_s = (timer_q == AA_LAST);
`else
  assign auto_ans_s = 1'b0;
`endif

  // A CALL_REQ from anyone but the peer while busy gets an automatic NAK.
  assign nak_s = rx_valid && (rx_type == PKT_REQ) && (state_q != S_IDLE) &&
                 (rx_src != peer_addr_q);

  // State register: FSM state, timer, peer and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      timer_q         <= {TMR_W{1'b0}};
      peer_addr_q     <= {ADDR_W{1'b0}};
      tx_valid_q      <= 1'b0;
      tx_type_q       <= PKT_NONE;
      tx_dst_q        <= {ADDR_W{1'b0}};
      inc_command_q   <= UI_NONE;
      incoming_call_q <= 1'b0;
      init_q          <= 1'b0;
      started_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      peer_addr_q     <= peer_addr_d;
      tx_valid_q      <= tx_valid_d;
      tx_type_q       <= tx_type_d;
      tx_dst_q        <= tx_dst_d;
      inc_command_q   <= inc_command_d;
      incoming_call_q <= incoming_call_d;
      init_q          <= init_d;
      started_q       <= started_d;
    end
  end

  // Next-state: call FSM transitions, packet requests, UI status and timer
  always_comb begin
    state_d     = state_q;
    peer_addr_d = peer_addr_q;
    send_s      = 1'b0;
    send_type_s = PKT_NONE;
    send_dst_s  = peer_addr_q;
    status_s    = UI_NONE;

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_type == PKT_REQ)) begin
          peer_addr_d = rx_src;
          status_s    = UI_RING;
          state_d     = S_RINGING;
        end else if (ui_ev_s && (ui_cmd == CMD_DIAL)) begin
          peer_addr_d = ui_addr;
          send_s      = 1'b1;
          send_type_s = PKT_REQ;
          send_dst_s  = ui_addr;
          state_d     = S_DIALING;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_DIALING: begin
        if (rx_peer_s && (rx_type == PKT_ACK)) begin
          status_s = UI_CONNECTED;
          state_d  = S_CONNECTED;
        end else if (rx_peer_s && (rx_type == PKT_NAK)) begin
          status_s = UI_BUSY;
          state_d  = S_IDLE;
        end else if (ui_ev_s && (ui_cmd == CMD_HANGUP)) begin
          send_s      = 1'b1;
          send_type_s = PKT_END;
          status_s    = UI_ENDED;
          state_d     = S_IDLE;
        end else if (timeout_s) begin
          status_s = UI_TIMEOUT;
          state_d  = S_IDLE;
        end else begin
          state_d = S_DIALING;
        end
      end

      S_RINGING: begin
        if (rx_peer_s && (rx_type == PKT_END)) begin
          status_s = UI_ENDED;
          state_d  = S_IDLE;
        end else if (ui_ev_s && (ui_cmd == CMD_ACCEPT)) begin
          send_s      = 1'b1;
          send_type_s = PKT_ACK;
          status_s    = UI_CONNECTED;
          state_d     = S_CONNECTED;
        end else if (ui_ev_s && (ui_cmd == CMD_REJECT)) begin
          send_s      = 1'b1;
          send_type_s = PKT_NAK;
          state_d     = S_IDLE;
        end else if (timeout_s) begin
          send_s      = 1'b1;
          send_type_s = PKT_NAK;
          status_s    = UI_TIMEOUT;
          state_d     = S_IDLE;
        end else if (auto_ans_s) begin
          send_s      = 1'b1;
          send_type_s = PKT_ACK;
          status_s    = UI_CONNECTED;
          state_d     = S_CONNECTED;
        end else begin
          state_d = S_RINGING;
        end
      end

      S_CONNECTED: begin
        if (rx_peer_s && (rx_type == PKT_END)) begin
          status_s = UI_ENDED;
          state_d  = S_IDLE;
        end else if (ui_ev_s && (ui_cmd == CMD_HANGUP)) begin
          send_s      = 1'b1;
          send_type_s = PKT_END;
          status_s    = UI_ENDED;
          state_d     = S_IDLE;
        end else begin
          state_d = S_CONNECTED;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The timer restarts on every state change and saturates instead of
    // wrapping, so a stalled compare can never re-arm.
    if (state_d != state_q) begin
      timer_d = {TMR_W{1'b0}};
    end else if (((state_q == S_DIALING) || (state_q == S_RINGING)) &&
                 (timer_q != TMR_SAT)) begin
      timer_d = timer_q + TMR_W'(1);
    end else begin
      timer_d = timer_q;
    end
  end

  // Output: TX slot arbitration, status pulse, ringing level and init pulse
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_type_d  = tx_type_q;
    tx_dst_d   = tx_dst_q;

    // Only one packet can be outstanding. Any request raised while the slot
    // is busy is dropped. FSM packets take priority over the auto-NAK.
    if (tx_valid_q) begin
      if (tx_ready) begin
        tx_valid_d = 1'b0;
        tx_type_d  = PKT_NONE;
        tx_dst_d   = {ADDR_W{1'b0}};
      end else begin
        tx_valid_d = 1'b1;
      end
    end else if (send_s) begin
      tx_valid_d = 1'b1;
      tx_type_d  = send_type_s;
      tx_dst_d   = send_dst_s;
    end else if (nak_s) begin
      tx_valid_d = 1'b1;
      tx_type_d  = PKT_NAK;
      tx_dst_d   = rx_src;
    end else begin
      tx_valid_d = 1'b0;
      tx_type_d  = PKT_NONE;
      tx_dst_d   = {ADDR_W{1'b0}};
    end

    inc_command_d   = status_s;
    incoming_call_d = (state_d == S_RINGING);
    init_d          = !started_q;
    started_d       = 1'b1;
  end

  assign tx_valid      = tx_valid_q;
  assign tx_type       = tx_type_q;
  assign tx_dst        = tx_dst_q;
  assign inc_command   = inc_command_q;
  assign init          = init_q;
  assign incoming_call = incoming_call_q;
  assign peer_addr     = peer_addr_q;

endmodule

// File: tb/tb_call_control.sv
// ---------------------------------------------------------------------------
// tb_call_control
//
// Self-checking bench for call_control (TIMEOUT_CYCLES=20, AUTO_ANS_CYCLES=8).
// A vector table drives one cycle per record. Each record's expected outputs
// are pushed to a scoreboard queue and compared one cycle later. Hand-written
// sequences cover the timeouts, TX backpressure and reset in the middle of a
// call.
// ---------------------------------------------------------------------------
module tb_call_control;

  localparam int unsigned AW  = 8;
  localparam int unsigned TMO = 20;
  localparam int unsigned AA  = 8;

  localparam logic [2:0] C_NOP = 3'd0, C_DIAL = 3'd1, C_ACC = 3'd2, C_REJ = 3'd3, C_HUP = 3'd4;
  localparam logic [2:0] P_NONE = 3'd0, P_REQ = 3'd1, P_ACK = 3'd2, P_NAK = 3'd3, P_END = 3'd4;
  localparam logic [2:0] U_NONE = 3'd0, U_RING = 3'd1, U_CONN = 3'd2, U_BUSY = 3'd3,
                         U_END = 3'd4, U_TMO = 3'd5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [2:0]    ui_cmd = 3'd0;
  logic          ui_cmd_valid = 1'b0;
  logic [AW-1:0] ui_addr = 8'h00;
  logic          rx_valid = 1'b0;
  logic [2:0]    rx_type = 3'd0;
  logic [AW-1:0] rx_src = 8'h00;
  logic          tx_ready = 1'b1;
  logic          tx_valid;
  logic [2:0]    tx_type;
  logic [AW-1:0] tx_dst;
  logic [2:0]    inc_command;
  logic          init;
  logic          incoming_call;
  logic [AW-1:0] peer_addr;

  always #5 clk = ~clk;

  call_control #(
    .TIMEOUT_CYCLES (TMO),
    .AUTO_ANS_CYCLES(AA),
    .ADDR_W         (AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ui_cmd       (ui_cmd),
    .ui_cmd_valid (ui_cmd_valid),
    .ui_addr      (ui_addr),
    .rx_valid     (rx_valid),
    .rx_type      (rx_type),
    .rx_src       (rx_src),
    .tx_valid     (tx_valid),
    .tx_type      (tx_type),
    .tx_dst       (tx_dst),
    .tx_ready     (tx_ready),
    .inc_command  (inc_command),
    .init         (init),
    .incoming_call(incoming_call),
    .peer_addr    (peer_addr)
  );

  typedef struct {
    logic uv; logic [2:0] cmd; logic [7:0] addr;
    logic rv; logic [2:0] rt;  logic [7:0] rs;  logic rdy;
    logic tv; logic [2:0] tt;  logic [7:0] td;
    logic [2:0] inc; logic ring; logic [7:0] peer;
  } vec_t;

  typedef struct {
    logic tv; logic [2:0] tt; logic [7:0] td;
    logic [2:0] inc; logic ring; logic [7:0] peer;
    string tag;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic uv, input logic [2:0] cmd, input logic [7:0] addr,
                              input logic rv, input logic [2:0] rt, input logic [7:0] rs,
                              input logic rdy, input logic tv, input logic [2:0] tt,
                              input logic [7:0] td, input logic [2:0] inc, input logic ring,
                              input logic [7:0] peer);
    vec_t v;
    v.uv = uv; v.cmd = cmd; v.addr = addr; v.rv = rv; v.rt = rt; v.rs = rs; v.rdy = rdy;
    v.tv = tv; v.tt = tt; v.td = td; v.inc = inc; v.ring = ring; v.peer = peer;
    return v;
  endfunction

  // UI command with tx_ready high
  function automatic vec_t vui(input logic [2:0] cmd, input logic [7:0] addr, input logic tv,
                               input logic [2:0] tt, input logic [7:0] td, input logic [2:0] inc,
                               input logic ring, input logic [7:0] peer);
    return mk(1'b1, cmd, addr, 1'b0, P_NONE, 8'h00, 1'b1, tv, tt, td, inc, ring, peer);
  endfunction

  // Received packet with tx_ready high
  function automatic vec_t vrx(input logic [2:0] rt, input logic [7:0] rs, input logic tv,
                               input logic [2:0] tt, input logic [7:0] td, input logic [2:0] inc,
                               input logic ring, input logic [7:0] peer);
    return mk(1'b0, C_NOP, 8'h00, 1'b1, rt, rs, 1'b1, tv, tt, td, inc, ring, peer);
  endfunction

  // Quiet cycle with tx_ready high; expects no packet and no status pulse
  function automatic vec_t quiet(input logic ring, input logic [7:0] peer);
    return mk(1'b0, C_NOP, 8'h00, 1'b0, P_NONE, 8'h00, 1'b1,
              1'b0, P_NONE, 8'h00, U_NONE, ring, peer);
  endfunction

  // Drive one cycle, queue its expectation, then compare once the edge has passed
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    ui_cmd_valid = v.uv; ui_cmd = v.cmd; ui_addr = v.addr;
    rx_valid = v.rv; rx_type = v.rt; rx_src = v.rs; tx_ready = v.rdy;
    e.tv = v.tv; e.tt = v.tt; e.td = v.td; e.inc = v.inc; e.ring = v.ring; e.peer = v.peer;
    e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    ui_cmd_valid = 1'b0; rx_valid = 1'b0;
    e = sb_q.pop_front();
    chk({e.tag, "/tx_valid"}, tx_valid, e.tv);
    if (e.tv) begin
      chk({e.tag, "/tx_type"}, tx_type, e.tt);
      chk({e.tag, "/tx_dst"}, tx_dst, e.td);
    end
    chk({e.tag, "/inc_command"}, inc_command, e.inc);
    chk({e.tag, "/incoming_call"}, incoming_call, e.ring);
    chk({e.tag, "/peer_addr"}, peer_addr, e.peer);
    chk({e.tag, "/init"}, init, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "/tx_valid"}, tx_valid, 1'b0);
    chk({tag, "/tx_type"}, tx_type, 3'd0);
    chk({tag, "/tx_dst"}, tx_dst, 8'h00);
    chk({tag, "/inc_command"}, inc_command, 3'd0);
    chk({tag, "/init"}, init, 1'b0);
    chk({tag, "/incoming_call"}, incoming_call, 1'b0);
    chk({tag, "/peer_addr"}, peer_addr, 8'h00);
  endtask

  // Release reset away from the edge; init must pulse for exactly one cycle
  task automatic release_and_init(input string tag);
    reset = 1'b0;
    @(posedge clk); #1;
    chk({tag, "/init_hi"}, init, 1'b1);
    chk({tag, "/tx_valid"}, tx_valid, 1'b0);
    chk({tag, "/inc_command"}, inc_command, 3'd0);
    chk({tag, "/incoming_call"}, incoming_call, 1'b0);
    chk({tag, "/peer_addr"}, peer_addr, 8'h00);
    @(posedge clk); #1;
    chk({tag, "/init_lo"}, init, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d/%0d so far", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset value table
    #1 reset = 1'b1;
    #2 check_reset_vals("reset");
    @(posedge clk); #1;
    release_and_init("release");

    // Main table: one record per clock
    tbl.push_back(vui(C_DIAL, 8'h2A, 1'b1, P_REQ, 8'h2A, U_NONE, 1'b0, 8'h2A));
    tbl.push_back(quiet(1'b0, 8'h2A));
    tbl.push_back(vrx(P_ACK, 8'h2A, 1'b0, P_NONE, 8'h00, U_CONN, 1'b0, 8'h2A));
    tbl.push_back(quiet(1'b0, 8'h2A));
    tbl.push_back(vrx(P_REQ, 8'h33, 1'b1, P_NAK, 8'h33, U_NONE, 1'b0, 8'h2A));
    tbl.push_back(quiet(1'b0, 8'h2A));
    tbl.push_back(vui(C_HUP, 8'h00, 1'b1, P_END, 8'h2A, U_END, 1'b0, 8'h2A));
    tbl.push_back(quiet(1'b0, 8'h2A));
    tbl.push_back(vui(C_ACC, 8'h00, 1'b0, P_NONE, 8'h00, U_NONE, 1'b0, 8'h2A));
    tbl.push_back(vrx(P_REQ, 8'h11, 1'b0, P_NONE, 8'h00, U_RING, 1'b1, 8'h11));
    tbl.push_back(quiet(1'b1, 8'h11));
    tbl.push_back(vrx(P_END, 8'h55, 1'b0, P_NONE, 8'h00, U_NONE, 1'b1, 8'h11));
    // rx and UI in the same cycle: the ACCEPT must be discarded
    tbl.push_back(mk(1'b1, C_ACC, 8'h00, 1'b1, P_NONE, 8'h11, 1'b1,
                     1'b0, P_NONE, 8'h00, U_NONE, 1'b1, 8'h11));
    tbl.push_back(vrx(P_END, 8'h11, 1'b0, P_NONE, 8'h00, U_END, 1'b0, 8'h11));
    tbl.push_back(quiet(1'b0, 8'h11));
    tbl.push_back(vrx(P_REQ, 8'h44, 1'b0, P_NONE, 8'h00, U_RING, 1'b1, 8'h44));
    tbl.push_back(vui(C_ACC, 8'h00, 1'b1, P_ACK, 8'h44, U_CONN, 1'b0, 8'h44));
    tbl.push_back(quiet(1'b0, 8'h44));
    tbl.push_back(vrx(P_END, 8'h44, 1'b0, P_NONE, 8'h00, U_END, 1'b0, 8'h44));
    tbl.push_back(vui(C_DIAL, 8'h5C, 1'b1, P_REQ, 8'h5C, U_NONE, 1'b0, 8'h5C));
    tbl.push_back(quiet(1'b0, 8'h5C));
    tbl.push_back(vrx(P_NAK, 8'h5C, 1'b0, P_NONE, 8'h00, U_BUSY, 1'b0, 8'h5C));
    tbl.push_back(quiet(1'b0, 8'h5C));
    tbl.push_back(vrx(P_REQ, 8'h66, 1'b0, P_NONE, 8'h00, U_RING, 1'b1, 8'h66));
    tbl.push_back(vui(C_REJ, 8'h00, 1'b1, P_NAK, 8'h66, U_NONE, 1'b0, 8'h66));
    tbl.push_back(quiet(1'b0, 8'h66));
    tbl.push_back(vui(3'd7, 8'h99, 1'b0, P_NONE, 8'h00, U_NONE, 1'b0, 8'h66));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

`ifdef CALL_CTRL_AUTOANSWER_EN
    // Ringing is answered automatically on the 8th cycle
    step(vrx(P_REQ, 8'h11, 1'b0, P_NONE, 8'h00, U_RING, 1'b1, 8'h11), "aa_req");
    for (int i = 0; i < AA - 1; i++) step(quiet(1'b1, 8'h11), $sformatf("aa_wait%0d", i));
    step(mk(1'b0, C_NOP, 8'h00, 1'b0, P_NONE, 8'h00, 1'b1,
            1'b1, P_ACK, 8'h11, U_CONN, 1'b0, 8'h11), "aa_answer");
    step(quiet(1'b0, 8'h11), "aa_hs");
    step(vui(C_HUP, 8'h00, 1'b1, P_END, 8'h11, U_END, 1'b0, 8'h11), "aa_hangup");
    step(quiet(1'b0, 8'h11), "aa_idle");
`else
    // Unanswered ring: NAK plus TIMEOUT exactly 20 cycles after entry, no auto-answer
    step(vrx(P_REQ, 8'h11, 1'b0, P_NONE, 8'h00, U_RING, 1'b1, 8'h11), "rt_req");
    for (int i = 0; i < TMO - 1; i++) step(quiet(1'b1, 8'h11), $sformatf("rt_wait%0d", i));
    step(mk(1'b0, C_NOP, 8'h00, 1'b0, P_NONE, 8'h00, 1'b1,
            1'b1, P_NAK, 8'h11, U_TMO, 1'b0, 8'h11), "rt_timeout");
    step(quiet(1'b0, 8'h11), "rt_idle");
`endif

    // Unanswered dial: TIMEOUT pulse after 20 cycles, no packet; a late ACK is ignored
    step(vui(C_DIAL, 8'h77, 1'b1, P_REQ, 8'h77, U_NONE, 1'b0, 8'h77), "dt_dial");
    for (int i = 0; i < TMO - 1; i++) step(quiet(1'b0, 8'h77), $sformatf("dt_wait%0d", i));
    step(mk(1'b0, C_NOP, 8'h00, 1'b0, P_NONE, 8'h00, 1'b1,
            1'b0, P_NONE, 8'h00, U_TMO, 1'b0, 8'h77), "dt_timeout");
    step(vrx(P_ACK, 8'h77, 1'b0, P_NONE, 8'h00, U_NONE, 1'b0, 8'h77), "dt_late_ack");

    // Backpressure: packet held stable 5 cycles; auto-NAK raised meanwhile is dropped
    step(mk(1'b1, C_DIAL, 8'h2A, 1'b0, P_NONE, 8'h00, 1'b0,
            1'b1, P_REQ, 8'h2A, U_NONE, 1'b0, 8'h2A), "bp_dial");
    step(mk(1'b0, C_NOP, 8'h00, 1'b1, P_REQ, 8'h99, 1'b0,
            1'b1, P_REQ, 8'h2A, U_NONE, 1'b0, 8'h2A), "bp_nak_drop");
    for (int i = 0; i < 3; i++)
      step(mk(1'b0, C_NOP, 8'h00, 1'b0, P_NONE, 8'h00, 1'b0,
              1'b1, P_REQ, 8'h2A, U_NONE, 1'b0, 8'h2A), $sformatf("bp_hold%0d", i));
    step(quiet(1'b0, 8'h2A), "bp_handshake");
    step(quiet(1'b0, 8'h2A), "bp_single");
    step(vui(C_HUP, 8'h00, 1'b1, P_END, 8'h2A, U_END, 1'b0, 8'h2A), "bp_hangup");
    step(quiet(1'b0, 8'h2A), "bp_idle");

    // Reset mid-call with a packet pending: immediate clear, nothing resent
    step(mk(1'b1, C_DIAL, 8'h2A, 1'b0, P_NONE, 8'h00, 1'b0,
            1'b1, P_REQ, 8'h2A, U_NONE, 1'b0, 8'h2A), "mr_dial");
    reset = 1'b1;
    #1 check_reset_vals("mr_async");
    @(posedge clk); #1;
    release_and_init("mr_release");
    step(mk(1'b0, C_NOP, 8'h00, 1'b0, P_NONE, 8'h00, 1'b0,
            1'b0, P_NONE, 8'h00, U_NONE, 1'b0, 8'h00), "mr_no_tx");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
